cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Control state machine that consumes the instruction decoder's opcode/op fields and sequences the register-file/ALU datapath one micro-step per clock.
- Drives the decoder's one-hot register select (nsel) and all datapath load/select/write strobes.
- Sits between the instruction register/decoder and the datapath. Handshakes with the top level via start (s) and wait (w).

Parameters:
- STATE_W, 4, width of the encoded state register; must be >= 4. Encoding is implementation-chosen but fixed.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- s  input  1  start: execute the instruction currently presented on opcode/op.
- opcode  input  3  instruction class from the decoder.
- op  input  2  sub-operation from the decoder.
- w  output  1  high only in WAIT (ready for s).
- nsel  output  3  one-hot register select: 100 Rn, 010 Rd, 001 Rm, 000 none.
- vsel  output  2  writeback source: 00 C, 01 PC, 10 sximm8, 11 mdata.
- loada, loadb, loadc, loads  output  1 each  datapath register load enables.
- asel  output  1  1 = force ALU A operand to zero.
- bsel  output  1  1 = ALU B operand from sximm5 (always 0 in this block).
- write  output  1  register-file write enable.

Behaviour:
- Moore machine: all outputs are decoded from the state register plus the latched {opcode,op}, with no combinational path from s.
- Reset (async, reset_n low): state = WAIT, w = 1, nsel = 000, vsel = 00, and all strobes, asel, and bsel = 0, effective immediately mid-instruction. Latched fields are cleared to 0.
- In every state, any output not listed for that state is 0 and vsel = 00.
- WAIT: w = 1. If s = 1 at the edge, capture {opcode,op} into an internal register and go to DECODE; else stay. s is ignored in all other states.
- DECODE: no strobes. Next state from the latched fields:
  - 110/10 -> WRITE_IMM.
  - 110/00 (MOV reg) or 101/11 (MVN) -> GET_B.
  - 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GET_A.
  - Any other encoding -> WAIT.
- GET_A: nsel = 100, loada = 1 -> GET_B.
- GET_B: nsel = 001, loadb = 1 -> ALU.
- ALU:
  - loadc = 1.
  - asel = 1 for MOV reg and MVN.
  - For CMP: loadc = 0, loads = 1, next state WAIT.
  - Otherwise next state WRITE_REG.
- WRITE_REG: nsel = 010, vsel = 00, write = 1 -> WAIT.
- WRITE_IMM: nsel = 100, vsel = 10, write = 1 -> WAIT.
- Cycles with w = 0 per instruction: MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD/AND 5, unsupported 1.
- s held high continuously: at least one cycle in WAIT with w = 1 between instructions; the next instruction is captured on that cycle's edge.
- opcode/op changing after capture has no effect on the instruction in flight.
- Exactly one of loada/loadb/loadc/loads/write is high in any cycle, or none.

Optional Feature:
- Macro CPU_CTRL_ILLEGAL_EN.
- Defined:
  - Adds output port err (1 bit), registered, reset 0.
  - Set on the DECODE -> WAIT transition for an unsupported encoding.
  - Cleared when the next s is accepted in WAIT.
  - Sticky while idle.
- Undefined: port absent; unsupported encodings silently return to WAIT after one DECODE cycle.

Test Plan:
- Reset, then opcode=110, op=10, s pulse -> DECODE, then WRITE_IMM with nsel=100, vsel=10, write=1 for one cycle; w low exactly 2 cycles.
- opcode=101, op=00 (ADD), s=1 -> loada with nsel=100, loadb with nsel=001, loadc with asel=0, write with nsel=010, vsel=00, in consecutive cycles; w low exactly 5 cycles.
- opcode=101, op=01 (CMP) -> loads=1 in the ALU cycle, write never asserted, back in WAIT after 4 cycles. Repeat with op=11 (MVN) -> GET_A skipped, asel=1 in ALU.
- s held high with opcode=110, op=00 -> back-to-back instructions separated by exactly one w=1 cycle; flipping opcode mid-instruction does not change the strobe sequence.
- reset_n dropped during GET_B of an ADD -> state WAIT and all strobes 0 before the next clock edge; s after release executes normally.
- opcode=111, op=00, s pulse -> one DECODE cycle, no strobes, w returns to 1. With CPU_CTRL_ILLEGAL_EN, err=1 until the next accepted s.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: Moore control sequencer for the register-file/ALU datapath, one micro-step per clock.
// Optional CPU_CTRL_ILLEGAL_EN adds a sticky err flag for unsupported encodings.
module cpu_ctrl_fsm #(
   parameter int STATE_W = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       s,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic       w,
   output logic [2:0] nsel,
   output logic [1:0] vsel,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
`ifdef CPU_CTRL_ILLEGAL_EN
   output logic       write,
   output logic       err
`else
   output logic       write
`endif
);
   typedef enum logic [STATE_W-1:0] {WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM} state_t;
   state_t state, nxt;
   logic [4:0] ins;
   logic movi, movr, mvn, add, cmp, andi;
   assign movi = ins == 5'b110_10;
   assign movr = ins == 5'b110_00;
   assign mvn  = ins == 5'b101_11;
   assign add  = ins == 5'b101_00;
   assign cmp  = ins == 5'b101_01;
   assign andi = ins == 5'b101_10;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= WAIT;
         ins   <= '0;
      end else begin
         state <= nxt;
         if (state == WAIT && s) ins <= {opcode, op};
      end
`ifdef CPU_CTRL_ILLEGAL_EN
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) err <= 1'b0;
      else if (state == WAIT && s) err <= 1'b0;
      else if (state == DECODE && nxt == WAIT) err <= 1'b1;
`endif
   always_comb begin
      nxt   = state;
      w     = 1'b0;
      nsel  = 3'b000;
      vsel  = 2'b00;
      loada = 1'b0;
      loadb = 1'b0;
      loadc = 1'b0;
      loads = 1'b0;
      asel  = 1'b0;
      bsel  = 1'b0;
      write = 1'b0;
      case (state)
         WAIT: begin
            w   = 1'b1;
            nxt = s ? DECODE : WAIT;
         end
         DECODE: nxt = movi ? WRITE_IMM : (movr || mvn) ? GET_B : (add || cmp || andi) ? GET_A : WAIT;
         GET_A: begin
            nsel  = 3'b100;
            loada = 1'b1;
            nxt   = GET_B;
         end
         GET_B: begin
            nsel  = 3'b001;
            loadb = 1'b1;
            nxt   = ALU;
         end
         ALU: begin
            asel  = movr || mvn;
            loadc = !cmp;
            loads = cmp;
            nxt   = cmp ? WAIT : WRITE_REG;
         end
         WRITE_REG: begin
            nsel  = 3'b010;
            write = 1'b1;
            nxt   = WAIT;
         end
         WRITE_IMM: begin
            nsel  = 3'b100;
            vsel  = 2'b10;
            write = 1'b1;
            nxt   = WAIT;
         end
         default: nxt = WAIT;
      endcase
   end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: randomized and directed checks of cpu_ctrl_fsm against a per-instruction micro-step model.
module tb_cpu_ctrl_fsm;
   typedef logic [12:0] vq_t[$];
   // vector layout: w, nsel[3], vsel[2], loada, loadb, loadc, loads, asel, bsel, write
   localparam logic [12:0] IDLE = 13'b1_000_00_0000000;
   localparam logic [12:0] DEC  = 13'b0_000_00_0000000;
   localparam logic [12:0] GA   = 13'b0_100_00_1000000;
   localparam logic [12:0] GB   = 13'b0_001_00_0100000;
   localparam logic [12:0] AL   = 13'b0_000_00_0010000;
   localparam logic [12:0] ALZ  = 13'b0_000_00_0010100;
   localparam logic [12:0] CMPS = 13'b0_000_00_0001000;
   localparam logic [12:0] WR   = 13'b0_010_00_0000001;
   localparam logic [12:0] WIMM = 13'b0_100_10_0000001;
   logic clk = 0, reset_n = 0, s = 0;
   logic [2:0] opcode = 0;
   logic [1:0] op = 0;
   logic w, loada, loadb, loadc, loads, asel, bsel, write;
   logic [2:0] nsel;
   logic [1:0] vsel;
   logic err_exp = 0, cur_ill = 0;
   int checks = 0, errors = 0;
   vq_t q;
`ifdef CPU_CTRL_ILLEGAL_EN
   logic err;
`endif
   cpu_ctrl_fsm dut (
      .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op), .w(w), .nsel(nsel), .vsel(vsel),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
`ifdef CPU_CTRL_ILLEGAL_EN
      .write(write), .err(err)
`else
      .write(write)
`endif
   );
   always #5 clk = ~clk;
   wire [12:0] outv = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write};
   function automatic vq_t seq(input logic [4:0] i);
      vq_t r;
      r.push_back(DEC);
      case (i)
         5'b110_10: r.push_back(WIMM);
         5'b110_00, 5'b101_11: begin r.push_back(GB); r.push_back(ALZ); r.push_back(WR); end
         5'b101_01: begin r.push_back(GA); r.push_back(GB); r.push_back(CMPS); end
         5'b101_00, 5'b101_10: begin r.push_back(GA); r.push_back(GB); r.push_back(AL); r.push_back(WR); end
         default: ;
      endcase
      return r;
   endfunction
   function automatic logic legal(input logic [4:0] i);
      return i inside {5'b110_10, 5'b110_00, 5'b101_11, 5'b101_00, 5'b101_01, 5'b101_10};
   endfunction
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
      end
   endtask
   always @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         q.delete();
         err_exp = 0;
      end else if (q.size() != 0) begin
         void'(q.pop_front());
         if (q.size() == 0 && cur_ill) err_exp = 1;
      end else if (s) begin
         q = seq({opcode, op});
         cur_ill = !legal({opcode, op});
         err_exp = 0;
      end
   always @(negedge clk) begin
      chk("outputs", 32'(outv), 32'(q.size() != 0 ? q[0] : IDLE));
      chk("one_strobe", 32'($countones({loada, loadb, loadc, loads, write}) <= 1), 32'd1);
`ifdef CPU_CTRL_ILLEGAL_EN
      chk("err", 32'(err), 32'(err_exp));
`endif
   end
   task automatic run(input logic [4:0] i, input int want, input string name);
      int lo;
      @(negedge clk); #1 s = 1; {opcode, op} = i;
      @(negedge clk); lo = w ? 0 : 1;
      #1 s = 0; {opcode, op} = 5'($urandom);
      while (lo > 0 && lo < 20) begin
         @(negedge clk);
         if (w) break;
         lo++;
      end
      chk(name, 32'(lo), 32'(want));
   endtask
   initial begin
      logic [4:0] tbl[8];
      int hi, n;
      tbl = '{5'b110_10, 5'b110_00, 5'b101_11, 5'b101_00, 5'b101_01, 5'b101_10, 5'b111_00, 5'b100_01};
      chk("len_movi", 32'(seq(5'b110_10).size()), 2);
      chk("len_mvn", 32'(seq(5'b101_11).size()), 4);
      chk("len_add", 32'(seq(5'b101_00).size()), 5);
      chk("len_bad", 32'(seq(5'b111_00).size()), 1);
      @(negedge clk);
      chk("reset_state", 32'(outv), 32'(IDLE));
      #1 reset_n = 1;
      run(5'b110_10, 2, "wlow_movi");
      run(5'b101_00, 5, "wlow_add");
      run(5'b101_01, 4, "wlow_cmp");
      run(5'b101_11, 4, "wlow_mvn");
      run(5'b110_00, 4, "wlow_movr");
      run(5'b101_10, 5, "wlow_and");
      run(5'b111_00, 1, "wlow_bad");
`ifdef CPU_CTRL_ILLEGAL_EN
      repeat (2) @(negedge clk);
      chk("err_sticky", 32'(err), 1);
`endif
      // abort an ADD in GET_B with an async reset between edges
      @(negedge clk); #1 s = 1; {opcode, op} = 5'b101_00;
      @(negedge clk); #1 s = 0;
      repeat (2) @(negedge clk);
      chk("in_getb", 32'(outv), 32'(GB));
      #1 reset_n = 0;
      #1 chk("async_reset", 32'(outv), 32'(IDLE));
      @(negedge clk); #1 reset_n = 1;
      run(5'b101_00, 5, "after_reset");
      // s held high: one w=1 cycle between back-to-back MOV reg
      @(negedge clk); #1 s = 1; {opcode, op} = 5'b110_00;
      n = 0;
      while (w && n < 20) begin @(negedge clk); n++; end
      #1 {opcode, op} = 5'b111_11;
      @(negedge clk); #1 {opcode, op} = 5'b110_00;
      while (!w && n < 40) begin @(negedge clk); n++; end
      hi = 0;
      while (w && n < 60) begin @(negedge clk); hi++; n++; end
      chk("held_gap", 32'(hi), 1);
      repeat (8) @(negedge clk);
      #1 s = 0;
      repeat (6) @(negedge clk);
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         #1 s = ($urandom_range(2) != 0);
         {opcode, op} = ($urandom_range(7) == 7) ? 5'($urandom) : tbl[$urandom_range(7)];
         if ($urandom_range(60) == 0) begin
            #2 reset_n = 0;
            #1 reset_n = 1;
         end
      end
      #1 s = 0;
      repeat (8) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
